// File: rtl/ps2_pkg.sv
// Shared PS/2 constants, frame FSM encoding and the odd-parity helper.
// Imported by the frame receiver and by the downstream scancode decoder.
package ps2_pkg;

  localparam int PS2_FRAME_BITS = 11;
  localparam int PS2_DATA_BITS  = 8;

  // Prefix bytes consumed by the downstream decoder, not by the receiver.
  localparam logic [7:0] BREAK_CODE = 8'hF0;
  localparam logic [7:0] EXT_CODE   = 8'hE0;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DATA   = 2'd1,
    PARITY = 2'd2,
    STOP   = 2'd3
  } ps2_state_e;

  // A frame carries odd parity, so data bits plus parity bit XOR to 1.
  function automatic logic odd_parity_ok(input logic [PS2_DATA_BITS-1:0] d,
                                         input logic                     p);
    return ^{d, p};
  endfunction

endpackage

// File: rtl/ps2_byte_fifo.sv
// Synchronous FIFO with wrap-bit pointers; a push while full is dropped unless a
// pop happens in the same cycle, and stored entries are never overwritten.
module ps2_byte_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   push,
  input  logic                   pop,
  input  logic [WIDTH-1:0]       din,
  output logic [WIDTH-1:0]       dout,
  output logic [$clog2(DEPTH):0] level,
  output logic                   full,
  output logic                   empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW:0]      r_wr_ptr;
  logic [AW:0]      r_rd_ptr;
  logic             w_do_push;
  logic             w_do_pop;

  // Same index with opposite wrap bits means the writer has lapped the reader.
  assign empty = (r_wr_ptr == r_rd_ptr);
  assign full  = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                 (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);

  assign w_do_pop  = pop & ~empty;
  assign w_do_push = push & (~full | w_do_pop);

  assign level = r_wr_ptr - r_rd_ptr;
  assign dout  = empty ? '0 : r_mem[r_rd_ptr[AW-1:0]];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (w_do_push) r_mem[r_wr_ptr[AW-1:0]] <= din;
  end

endmodule

// File: rtl/ps2_frame_rx.sv
// PS/2 receive front end: synchronises the pins, assembles 11-bit frames and
// queues good bytes; detect is 3-4 clk after a pin edge, downstream stalls via data_ready.
module ps2_frame_rx
  import ps2_pkg::*;
#(
  parameter int FIFO_DEPTH     = 8,
  parameter int TIMEOUT_CYCLES = 50000
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        ps2_clk,
  input  logic                        ps2_data,
  output logic [7:0]                  data_out,
  output logic                        data_valid,
  input  logic                        data_ready,
  output logic [$clog2(FIFO_DEPTH):0] fifo_level,
  output logic [3:0]                  bit_cnt,
  output logic                        parity_err,
  output logic                        frame_err,
  output logic                        overflow
);

  localparam int              TW       = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TW-1:0]   TMO_LAST = TW'(TIMEOUT_CYCLES - 1);

  logic [2:0]               r_clk_sync;
  logic [2:0]               r_dat_sync;
  logic                     r_clk_prev;
  ps2_state_e               r_state;
  logic [3:0]               r_bit_cnt;
  logic [PS2_DATA_BITS-1:0] r_shift;
  logic                     r_parity;
  logic [TW-1:0]            r_tmo_cnt;
  logic                     r_parity_err;
  logic                     r_frame_err;
  logic                     r_overflow;

  logic                     w_fall;
  logic                     w_bit;
  ps2_state_e               w_state_nxt;
  logic [3:0]               w_bit_cnt_nxt;
  logic [PS2_DATA_BITS-1:0] w_shift_nxt;
  logic                     w_parity_nxt;
  logic [TW-1:0]            w_tmo_nxt;
  logic                     w_push;
  logic                     w_perr_nxt;
  logic                     w_ferr_nxt;
  logic                     w_full;
  logic                     w_empty;
  logic                     w_pop;

  // Synchronisers preset to the idle-high bus level so reset never fakes an edge.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_clk_sync <= 3'b111;
      r_dat_sync <= 3'b111;
      r_clk_prev <= 1'b1;
    end else begin
      r_clk_sync <= {r_clk_sync[1:0], ps2_clk};
      r_dat_sync <= {r_dat_sync[1:0], ps2_data};
      r_clk_prev <= r_clk_sync[2];
    end
  end

  assign w_fall = r_clk_prev & ~r_clk_sync[2];
  assign w_bit  = r_dat_sync[2];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state      <= IDLE;
      r_bit_cnt    <= '0;
      r_shift      <= '0;
      r_parity     <= 1'b0;
      r_tmo_cnt    <= '0;
      r_parity_err <= 1'b0;
      r_frame_err  <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_bit_cnt    <= w_bit_cnt_nxt;
      r_shift      <= w_shift_nxt;
      r_parity     <= w_parity_nxt;
      r_tmo_cnt    <= w_tmo_nxt;
      r_parity_err <= w_perr_nxt;
      r_frame_err  <= w_ferr_nxt;
    end
  end

  always_comb begin
    w_state_nxt   = r_state;
    w_bit_cnt_nxt = r_bit_cnt;
    w_shift_nxt   = r_shift;
    w_parity_nxt  = r_parity;
    w_tmo_nxt     = r_tmo_cnt;
    w_push        = 1'b0;
    w_perr_nxt    = 1'b0;
    w_ferr_nxt    = 1'b0;

    if (r_state == IDLE || w_fall) begin
      w_tmo_nxt = '0;
    end else begin
      w_tmo_nxt = r_tmo_cnt + 1'b1;
    end

    if (w_fall) begin
      case (r_state)
        IDLE: begin
          if (!w_bit) begin
            w_state_nxt   = DATA;
            w_bit_cnt_nxt = 4'd1;
          end else begin
            w_ferr_nxt    = 1'b1;
            w_bit_cnt_nxt = 4'd0;
          end
        end
        DATA: begin
          w_shift_nxt   = {w_bit, r_shift[PS2_DATA_BITS-1:1]};
          w_bit_cnt_nxt = r_bit_cnt + 4'd1;
          if (r_bit_cnt == 4'd8) w_state_nxt = PARITY;
        end
        PARITY: begin
          w_parity_nxt  = w_bit;
          w_bit_cnt_nxt = 4'd10;
          w_state_nxt   = STOP;
        end
        STOP: begin
          w_state_nxt   = IDLE;
          w_bit_cnt_nxt = 4'd0;
          // Stop-bit failure outranks parity failure; only a clean frame pushes.
          if (!w_bit) begin
            w_ferr_nxt = 1'b1;
          end else if (!odd_parity_ok(r_shift, r_parity)) begin
            w_perr_nxt = 1'b1;
          end else begin
            w_push = 1'b1;
          end
        end
        default: begin
          w_state_nxt   = IDLE;
          w_bit_cnt_nxt = 4'd0;
        end
      endcase
    end else if (r_state != IDLE && r_tmo_cnt == TMO_LAST) begin
      w_state_nxt   = IDLE;
      w_bit_cnt_nxt = 4'd0;
      w_ferr_nxt    = 1'b1;
      w_tmo_nxt     = '0;
    end
  end

  assign w_pop = data_ready & ~w_empty;

  // Sticky drop flag: a good byte arrived with no room and no pop to make room.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_overflow <= 1'b0;
    end else if (w_push && w_full && !w_pop) begin
      r_overflow <= 1'b1;
    end
  end

  ps2_byte_fifo #(
    .WIDTH (PS2_DATA_BITS),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (w_push),
    .pop   (data_ready),
    .din   (r_shift),
    .dout  (data_out),
    .level (fifo_level),
    .full  (w_full),
    .empty (w_empty)
  );

  assign data_valid = ~w_empty;
  assign bit_cnt    = r_bit_cnt;
  assign parity_err = r_parity_err;
  assign frame_err  = r_frame_err;
  assign overflow   = r_overflow;

endmodule

// File: tb/tb_ps2_frame_rx.sv
// Randomised PS/2 frame stimulus against a queue-based reference model; a
// monitor pops expected bytes whenever the receiver hands one downstream.
module tb_ps2_frame_rx;

  localparam int DEPTH = 8;
  localparam int TMO   = 100;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       ps2_clk = 1'b1;
  logic       ps2_data = 1'b1;
  logic       data_ready = 1'b0;
  logic [7:0] data_out;
  logic       data_valid;
  logic [3:0] fifo_level;
  logic [3:0] bit_cnt;
  logic       parity_err;
  logic       frame_err;
  logic       overflow;

  int         checks = 0;
  int         failures = 0;
  logic [7:0] exp_q[$];
  int         exp_perr = 0;
  int         exp_ferr = 0;
  int         perr_seen = 0;
  int         ferr_seen = 0;
  bit         exp_ovf = 1'b0;
  bit         prev_perr = 1'b0;
  bit         prev_ferr = 1'b0;
  int         ready_mode = 0;
  int         cyc = 0;
  int         last_fall_cyc = 0;
  logic [7:0] mon_exp;

  ps2_frame_rx #(
    .FIFO_DEPTH     (DEPTH),
    .TIMEOUT_CYCLES (TMO)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .ps2_clk    (ps2_clk),
    .ps2_data   (ps2_data),
    .data_out   (data_out),
    .data_valid (data_valid),
    .data_ready (data_ready),
    .fifo_level (fifo_level),
    .bit_cnt    (bit_cnt),
    .parity_err (parity_err),
    .frame_err  (frame_err),
    .overflow   (overflow)
  );

  always #5 clk = ~clk;

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  initial begin
    #900000;
    $display("FAIL watchdog: got no finish expected finish before time limit");
    $fatal(1);
  end

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
    end
  endtask

  // data_ready changes just after the rising edge so the monitor sees it stable.
  initial forever begin
    @(posedge clk);
    #2;
    case (ready_mode)
      0:       data_ready = 1'b0;
      1:       data_ready = 1'b1;
      default: data_ready = ($urandom_range(0, 3) != 0);
    endcase
  end

  initial forever begin
    @(negedge clk);
    if (reset) begin
      prev_perr = 1'b0;
      prev_ferr = 1'b0;
    end else begin
      if (data_valid && data_ready) begin
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL pop_unexpected: got 0x%02h expected no byte", data_out);
        end else begin
          mon_exp = exp_q.pop_front();
          check("pop_data", int'(data_out), int'(mon_exp));
        end
      end
      if (parity_err) perr_seen++;
      if (frame_err)  ferr_seen++;
      if (parity_err || frame_err) begin
        check("err_exclusive", int'(parity_err & frame_err), 0);
        check("pulse_width", int'((parity_err & prev_perr) | (frame_err & prev_ferr)), 0);
      end
      prev_perr = parity_err;
      prev_ferr = frame_err;
    end
  end

  // kind: 0 good, 1 wrong parity, 2 stop bit low
  function automatic logic [10:0] make_frame(input logic [7:0] d, input int kind);
    logic [10:0] f;
    f[0]   = 1'b0;
    f[8:1] = d;
    f[9]   = ($countones(d) % 2 == 0) ? 1'b1 : 1'b0;
    if (kind == 1) f[9] = ~f[9];
    f[10]  = (kind == 2) ? 1'b0 : 1'b1;
    return f;
  endfunction

  // Reference outcome of a whole frame, applied to the model before it is sent.
  task automatic model_frame(input logic [10:0] f);
    if (f[10] == 1'b0) begin
      exp_ferr++;
    end else if ($countones(f[9:1]) % 2 == 0) begin
      exp_perr++;
    end else if (exp_q.size() >= DEPTH) begin
      exp_ovf = 1'b1;
    end else begin
      exp_q.push_back(f[8:1]);
    end
  endtask

  task automatic send_bits(input logic [10:0] f, input int n, input bit chk);
    for (int k = 0; k < n; k++) begin
      ps2_data = f[k];
      repeat (4) @(posedge clk);
      #3;
      ps2_clk = 1'b0;
      last_fall_cyc = cyc;
      repeat (6) @(negedge clk);
      if (chk) check("bit_cnt_step", int'(bit_cnt), (k + 1 == 11) ? 0 : k + 1);
      repeat (2) @(posedge clk);
      #3;
      ps2_clk = 1'b1;
      repeat (4) @(posedge clk);
    end
    #3;
    ps2_data = 1'b1;
  endtask

  task automatic send_frame(input logic [7:0] d, input int kind, input bit chk);
    logic [10:0] f;
    f = make_frame(d, kind);
    model_frame(f);
    send_bits(f, 11, chk);
    repeat (20) @(negedge clk);
    check("parity_err_count", perr_seen, exp_perr);
    check("frame_err_count", ferr_seen, exp_ferr);
  endtask

  task automatic check_zero_outputs(input string tag);
    check({tag, "_data_out"},   int'(data_out),   0);
    check({tag, "_data_valid"}, int'(data_valid), 0);
    check({tag, "_fifo_level"}, int'(fifo_level), 0);
    check({tag, "_bit_cnt"},    int'(bit_cnt),    0);
    check({tag, "_parity_err"}, int'(parity_err), 0);
    check({tag, "_frame_err"},  int'(frame_err),  0);
    check({tag, "_overflow"},   int'(overflow),   0);
  endtask

  task automatic do_reset();
    @(posedge clk);
    #3;
    reset = 1'b1;
    @(negedge clk);
    check_zero_outputs("reset");
    exp_q.delete();
    exp_ovf = 1'b0;
    repeat (3) @(posedge clk);
    #3;
    reset = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  task automatic check_held(input string tag);
    check({tag, "_level"}, int'(fifo_level), exp_q.size());
    check({tag, "_valid"}, int'(data_valid), (exp_q.size() != 0) ? 1 : 0);
    check({tag, "_head"},  int'(data_out),   (exp_q.size() != 0) ? int'(exp_q[0]) : 0);
  endtask

  task automatic drain();
    ready_mode = 1;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (!data_valid && exp_q.size() == 0) break;
    end
    @(negedge clk);
    check("drain_valid", int'(data_valid), 0);
    check("drain_model_empty", exp_q.size(), 0);
    check("drain_data_out", int'(data_out), 0);
    check("drain_level", int'(fifo_level), 0);
    ready_mode = 0;
    repeat (2) @(negedge clk);
  endtask

  initial begin
    int t_seen;
    int kind;
    logic [7:0] d;

    repeat (3) @(posedge clk);
    @(negedge clk);
    check_zero_outputs("por");
    @(posedge clk);
    #3;
    reset = 1'b0;
    repeat (5) @(negedge clk);

    // One good frame held in the FIFO, bit counter tracked edge by edge.
    send_frame(8'h1C, 0, 1'b1);
    check_held("good_1c");

    // Error frames must leave the stored byte alone.
    send_frame(8'h1C, 1, 1'b0);
    check_held("bad_parity");
    send_frame(8'h3B, 2, 1'b0);
    check_held("bad_stop");
    exp_ferr++;
    send_bits(11'h7FF, 1, 1'b0);
    repeat (20) @(negedge clk);
    check("bad_start_ferr", ferr_seen, exp_ferr);
    check("bad_start_bit_cnt", int'(bit_cnt), 0);
    check_held("bad_start");
    drain();

    // Reset mid-frame with a byte queued, then a clean frame afterwards.
    send_frame(8'h77, 0, 1'b0);
    send_bits(make_frame(8'h29, 0), 5, 1'b0);
    check("partial_bit_cnt", int'(bit_cnt), 5);
    do_reset();
    send_frame(8'h29, 0, 1'b0);
    check_held("after_reset");
    drain();

    // Back-to-back frames with the consumer always ready.
    ready_mode = 1;
    send_frame(8'hF0, 0, 1'b0);
    send_frame(8'h1C, 0, 1'b0);
    drain();

    // Nine frames into eight entries: last byte lost, overflow sticks.
    for (int i = 1; i <= 9; i++) send_frame(8'(i), 0, 1'b0);
    check_held("full");
    check("full_overflow", int'(overflow), int'(exp_ovf));
    check("full_level_8", int'(fifo_level), DEPTH);
    drain();
    check("overflow_sticky", int'(overflow), 1);
    do_reset();
    check("overflow_cleared", int'(overflow), 0);

    // Abandoned frame: timeout fires TMO clocks after the last detected edge.
    send_bits(make_frame(8'h5A, 0), 4, 1'b0);
    check("stall_bit_cnt", int'(bit_cnt), 4);
    exp_ferr++;
    t_seen = -1;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      if (ferr_seen == exp_ferr) begin
        t_seen = cyc - last_fall_cyc;
        break;
      end
    end
    checks++;
    if (t_seen < TMO || t_seen > TMO + 12) begin
      failures++;
      $display("FAIL timeout_window: got %0d cycles expected %0d..%0d", t_seen, TMO, TMO + 12);
    end
    check("timeout_bit_cnt", int'(bit_cnt), 0);
    check("timeout_level", int'(fifo_level), 0);
    send_frame(8'h5A, 0, 1'b0);
    check_held("after_timeout");
    drain();

    // Random frames, random error kinds, random consumer stalls.
    ready_mode = 2;
    for (int n = 0; n < 40; n++) begin
      d = 8'($urandom);
      kind = $urandom_range(0, 9);
      send_frame(d, (kind < 7) ? 0 : ((kind < 9) ? 1 : 2), 1'b0);
      repeat ($urandom_range(0, 30)) @(posedge clk);
    end
    drain();
    check("final_overflow", int'(overflow), int'(exp_ovf));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
